mcp4921da: RTL
==============

// Module: mcp4921da
// PURPOSE
//  SPI master writer for an MCP4921 12-bit DAC. This is the output-side counterpart of the
//  MCP3201 ADC reader. On a start request it latches a 12-bit sample plus control bits, then
//  shifts a 16-bit command word MSB-first on dacsdi with daccs_n held low.
//  Runs on the same slow converter clock domain and signals completion with a one-cycle done pulse.
// PARAMETERS
//  CLKDIV  1  dacclk cycles per SCK half-period (>=1)
//  CSHI    2  min dacclk cycles daccs_n stays high between frames (>=1)
//  LDACW   2  dacldac_n low-pulse width in dacclk cycles (>=1; DAC_LDAC_EN builds only)
// PORTS
//  dacclk     in   1   converter clock (1.6 MHz nominal)
//  dacrst_n   in   1   asynchronous active-low reset
//  dacstart   in   1   request frame; sampled only in IDLE
//  dacdata    in   12  DAC code, latched on the accepting edge
//  dacbuf     in   1   Vref buffer bit (word bit 14)
//  dacga_n    in   1   gain bit, 1 = 1x (word bit 13)
//  dacshdn_n  in   1   active-low shutdown bit (word bit 12)
//  dacbusy    out  1   high from the accepting edge until done
//  dacdone    out  1   one-cycle pulse: frame complete, ready for next start
//  dacsck     out  1   SPI clock, idle low; DAC samples SDI on rising edge
//  dacsdi     out  1   SPI data out, MSB first
//  daccs_n    out  1   DAC chip select, active low
//  dacldac_n  out  1   DAC latch strobe, active low
// BEHAVIOUR
//  - Single clock, dacclk. Reset is asynchronous and active-low (dacrst_n).
//    In reset: daccs_n=1, dacsck=0, dacsdi=0, dacbusy=0, dacdone=0, dacldac_n=1
//    (dacldac_n=0 in builds without DAC_LDAC_EN). State = IDLE, counters = 0.
//  - Command word: shreg = {1'b0, dacbuf, dacga_n, dacshdn_n, dacdata}. Bit 15 = 0 selects channel A.
//  - IDLE: on a dacclk edge with dacstart=1, latch shreg and go to SHIFT_LO.
//    On the following cycle: daccs_n=0, dacbusy=1, dacsck=0, dacsdi=shreg[15].
//  - SHIFT_LO: dacsck=0 for CLKDIV cycles, then go to SHIFT_HI.
//  - SHIFT_HI: dacsck=1 for CLKDIV cycles. dacsdi is stable through the whole high phase.
//    At the end, bitcnt increments.
//    If bitcnt<15: shift left, drive the next bit, return to SHIFT_LO.
//    Otherwise: go to CS_HOLD.
//  - CS_HOLD: dacsck=0 for CLKDIV cycles, then daccs_n=1 and dacsdi=0.
//    daccs_n is low for exactly 33*CLKDIV cycles, with exactly 16 rising dacsck edges.
//  - GUARD: daccs_n high for CSHI cycles. On the last guard cycle's edge: dacdone=1 for one
//    cycle, dacbusy=0 on the same edge, state returns to IDLE. A start can be accepted on the
//    cycle after dacdone.
//  - dacstart held high back-to-back: consecutive frames separated by at least CSHI+1 high cycles.
//  - dacstart while busy: ignored, not queued. dacdata and control-bit changes after acceptance
//    do not affect the frame in flight.
//  - Reset mid-frame: daccs_n rises and dacsck falls asynchronously. The frame is aborted,
//    no dacdone is issued, and the DAC discards the partial word.
//  - Counters: bitcnt 4 bits; half-period counter wide enough for max(CLKDIV, CSHI, LDACW).
// CONFIGURATION
//  DAC_LDAC_EN defined:
//    - After daccs_n rises, wait 1 cycle, then drive dacldac_n=0 for LDACW cycles, then 1.
//    - GUARD starts after dacldac_n returns high.
//    - Total cycles from acceptance to dacdone = 33*CLKDIV + 1 + LDACW + CSHI.
//  DAC_LDAC_EN undefined:
//    - dacldac_n is tied 0; the DAC updates on the daccs_n rising edge.
//    - Total cycles from acceptance to dacdone = 33*CLKDIV + CSHI.
// TESTING
//  T1 CLKDIV=1, dacdata=12'hA5C, buf=0, ga_n=1, shdn_n=1, one start pulse
//     -> bench SPI model captures 16'h3A5C; daccs_n low 33 cycles; 16 rising sck edges;
//        exactly one dacdone; dacbusy low on the same cycle as dacdone.
//  T2 CLKDIV=3, dacdata=12'hFFF, shdn_n=0
//     -> captures 16'h2FFF; sck high/low 3 cycles each; daccs_n low 99 cycles.
//  T3 dacstart held high, data 12'h001 then 12'h800
//     -> two frames 16'h3001 and 16'h3800; daccs_n high >= CSHI cycles between them;
//        data changed mid-frame is not captured.
//  T4 dacrst_n pulsed low at the 8th rising sck edge
//     -> daccs_n=1 and dacsck=0 immediately, before the next dacclk edge; no dacdone;
//        the next start yields a clean full frame.
//  T5 DAC_LDAC_EN, LDACW=2
//     -> dacldac_n low exactly 2 cycles, starting 1 cycle after daccs_n rises;
//        dacdone at cycle 33+1+2+CSHI from acceptance.
//  T6 dacstart pulsed while busy
//     -> ignored; exactly one frame; dacbusy never drops mid-frame.

Source files
------------

// File: rtl/mcp4921da.sv
// SPI master writer for the MCP4921 12-bit DAC: latches a sample plus control bits, shifts a
// 16-bit command word MSB-first and pulses dacdone. Optional LDAC strobe: define DAC_LDAC_EN.
`timescale 1ns/1ps

module mcp4921da #(
   parameter int CLKDIV = 1,
   parameter int CSHI   = 2,
   parameter int LDACW  = 2
) (
   input  logic        dacclk,
   input  logic        dacrst_n,
   input  logic        dacstart,
   input  logic [11:0] dacdata,
   input  logic        dacbuf,
   input  logic        dacga_n,
   input  logic        dacshdn_n,
   output logic        dacbusy,
   output logic        dacdone,
   output logic        dacsck,
   output logic        dacsdi,
   output logic        daccs_n,
   output logic        dacldac_n
);

   localparam int CMAX = (CLKDIV > CSHI) ? ((CLKDIV > LDACW) ? CLKDIV : LDACW)
                                         : ((CSHI > LDACW) ? CSHI : LDACW);
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] CSHI_LAST = CW'(CSHI - 1);
   localparam logic [CW-1:0] LDAC_LAST = CW'(LDACW - 1);

   typedef enum logic [2:0] {
      IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, LDAC_WAIT, LDAC_LO, GUARD
   } state_t;

   state_t        state, state_nx;
   logic [15:0]   shreg, shreg_nx;
   logic [3:0]    bitcnt, bitcnt_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          done_nx;
   logic          busy_nx, cs_n_nx, sck_nx, sdi_nx;

   // State register; the SPI pins are registered from the next state so they never glitch.
   always_ff @(posedge dacclk or negedge dacrst_n) begin
      if (!dacrst_n) begin
         state   <= IDLE;
         // NOTE: the shift register is reset too; it feeds dacsdi, so a known value matters.
         shreg   <= '0;
         bitcnt  <= '0;
         cnt     <= '0;
         dacdone <= 1'b0;
         dacbusy <= 1'b0;
         daccs_n <= 1'b1;
         dacsck  <= 1'b0;
         dacsdi  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state   <= state_nx;
         shreg   <= shreg_nx;
         bitcnt  <= bitcnt_nx;
         cnt     <= cnt_nx;
         dacdone <= done_nx;
         dacbusy <= busy_nx;
         daccs_n <= cs_n_nx;
         dacsck  <= sck_nx;
         dacsdi  <= sdi_nx;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_nx  = state;
      shreg_nx  = shreg;
      bitcnt_nx = bitcnt;
      cnt_nx    = cnt;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (dacstart) begin
               state_nx  = SHIFT_LO;
               shreg_nx  = {1'b0, dacbuf, dacga_n, dacshdn_n, dacdata};
               bitcnt_nx = '0;
               cnt_nx    = '0;
            end
         end
         SHIFT_LO: begin
            if (cnt == DIV_LAST) begin
               cnt_nx   = '0;
               state_nx = SHIFT_HI;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (cnt == DIV_LAST) begin
               cnt_nx    = '0;
               bitcnt_nx = bitcnt + 4'd1;
               // Last bit stays on dacsdi through CS_HOLD.
               if (bitcnt != 4'd15) begin
                  shreg_nx = {shreg[14:0], 1'b0};
                  state_nx = SHIFT_LO;
               end else begin
                  state_nx = CS_HOLD;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         CS_HOLD: begin
            if (cnt == DIV_LAST) begin
               cnt_nx = '0;
`ifdef DAC_LDAC_EN
               state_nx = LDAC_WAIT;
`else
               state_nx = GUARD;
`endif
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         LDAC_WAIT: begin
            cnt_nx   = '0;
            state_nx = LDAC_LO;
         end
         LDAC_LO: begin
            if (cnt == LDAC_LAST) begin
               cnt_nx   = '0;
               state_nx = GUARD;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         GUARD: begin
            if (cnt == CSHI_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output decode of the next state
   always_comb begin
      busy_nx = (state_nx != IDLE);
      cs_n_nx = !(state_nx inside {SHIFT_LO, SHIFT_HI, CS_HOLD});
      sck_nx  = (state_nx == SHIFT_HI);
      sdi_nx  = (state_nx inside {SHIFT_LO, SHIFT_HI, CS_HOLD}) ? shreg_nx[15] : 1'b0;
   end

`ifdef DAC_LDAC_EN
   logic ldac_q;

   always_ff @(posedge dacclk or negedge dacrst_n) begin
      if (!dacrst_n) ldac_q <= 1'b1;
      else           ldac_q <= (state_nx != LDAC_LO);
   end

   assign dacldac_n = ldac_q;
`else
   // DAC updates on the daccs_n rising edge.
   assign dacldac_n = 1'b0;
`endif

endmodule
